mem_port_arbiter: RTL and testbench

- Sequences the multicycle core's single memory port and shares it between two requesters: the CPU datapath (port 0) and a DMA/loader engine (port 1).
- Runs one transaction at a time over a fixed-latency memory.
- Uses CPU-first priority with a starvation limit that guarantees DMA progress.
- Provides a stall signal the control unit uses to hold its current state until the memory access completes.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter.
//   CPU port : cpu_req/we/addr/wdata in, cpu_rdata/done/stall out
//   DMA port : dma_req/we/addr/wdata in, dma_rdata/done out
//   Memory   : mem_en/we/addr/wdata out, mem_rdata in
//   Status   : busy out
// slave  = arbiter side, master = requesters + memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_done;
   logic              cpu_stall;
   logic              dma_req;
   logic              dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic [DATA_W-1:0] dma_rdata;
   logic              dma_done;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_done, cpu_stall,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      output dma_rdata, dma_done,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_done, cpu_stall,
      output dma_req, dma_we, dma_addr, dma_wdata,
      input  dma_rdata, dma_done,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the CPU
// datapath (port 0) and a DMA/loader engine (port 1), one transaction at a
// time. CPU has priority, but after STARVE_LIMIT consecutive CPU grants made
// while DMA was waiting, DMA wins the next arbitration.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_port_arbiter_if.slave (requester ports, memory port, busy)
// Transaction timing: request seen in IDLE at T, BUSY T+1..T+MEM_LAT,
// DONE (done pulse) at T+MEM_LAT+1, then back to IDLE.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MEM_LAT      = 2,
   parameter int STARVE_LIMIT = 3
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic              owner;          // 0 = CPU, 1 = DMA
   logic [LAT_W-1:0]  lat_cnt;
   logic [STV_W-1:0]  starve_cnt;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] dma_rdata_q;

   logic any_req, grant_dma, last_beat;

   assign any_req   = bus.cpu_req | bus.dma_req;
   // DMA wins when alone, or when it has waited through STARVE_LIMIT CPU grants
   assign grant_dma = bus.dma_req & (~bus.cpu_req | (starve_cnt == STV_MAX));
   assign last_beat = (lat_cnt == '0);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req)   state_nxt = BUSY;
         BUSY:    if (last_beat) state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner       <= 1'b0;
         lat_cnt     <= '0;
         starve_cnt  <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               // Only a CPU grant with DMA waiting counts toward starvation
               if (!bus.dma_req || grant_dma)
                  starve_cnt <= '0;
               else if (starve_cnt != STV_MAX)
                  starve_cnt <= starve_cnt + 1'b1;
               if (any_req) begin
                  owner       <= grant_dma;
                  mem_we_q    <= grant_dma ? bus.dma_we    : bus.cpu_we;
                  mem_addr_q  <= grant_dma ? bus.dma_addr  : bus.cpu_addr;
                  mem_wdata_q <= grant_dma ? bus.dma_wdata : bus.cpu_wdata;
                  lat_cnt     <= LAT_INIT;
               end
            end
            BUSY: begin
               if (!last_beat) begin
                  lat_cnt <= lat_cnt - 1'b1;
               end else begin
                  mem_we_q <= 1'b0;
                  if (!mem_we_q) begin
                     if (owner) dma_rdata_q <= bus.mem_rdata;
                     else       cpu_rdata_q <= bus.mem_rdata;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // mem_we_q is only set on entry to BUSY and cleared on leaving it, so it
   // can drive mem_we directly without gating by mem_en.
   assign bus.mem_en    = (state == BUSY);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_rdata = dma_rdata_q;
   assign bus.cpu_done  = (state == DONE) & ~owner;
   assign bus.dma_done  = (state == DONE) &  owner;
   assign bus.cpu_stall = bus.cpu_req & ~bus.cpu_done;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. Requester drivers push expected
// transactions into per-port queues; a negedge monitor runs a transaction-level
// model (phase counter + starvation rule) and checks every DUT output.
// CPU uses addresses 0x00..0x1C, DMA 0x20..0x3C, so each port's read data
// depends only on its own history.
module tb_mem_port_arbiter;
   localparam int LAT = 2;
   localparam int LIM = 2;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
   } txn_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_LIMIT(LIM))
      dut (.clk(clk), .reset(rst), .bus(bus));

   logic [1:0]  req_v = '0;
   logic [1:0]  we_v  = '0;
   logic [31:0] addr_v [2];
   logic [31:0] wd_v   [2];
   logic [31:0] mem_rd = '0;

   assign bus.cpu_req   = req_v[0];
   assign bus.cpu_we    = we_v[0];
   assign bus.cpu_addr  = addr_v[0];
   assign bus.cpu_wdata = wd_v[0];
   assign bus.dma_req   = req_v[1];
   assign bus.dma_we    = we_v[1];
   assign bus.dma_addr  = addr_v[1];
   assign bus.dma_wdata = wd_v[1];
   assign bus.mem_rdata = mem_rd;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_on = 0;

   txn_t cq[$];
   txn_t dq[$];
   int   glog[$];
   logic [31:0] mem_arr [logic [31:0]];
   logic [31:0] shadow0 [logic [31:0]];
   logic [31:0] shadow1 [logic [31:0]];

   // model state
   int          ph = 0;
   int          stv = 0;
   logic        own = 1'b0;
   logic [31:0] mrd0 = '0, mrd1 = '0;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
   endfunction

   function automatic logic [31:0] shadow_rd(input int p, input logic [31:0] a);
      if (p == 0) return shadow0.exists(a) ? shadow0[a] : init_val(a);
      return shadow1.exists(a) ? shadow1[a] : init_val(a);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, want, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Fixed-latency memory: data is only valid on the MEM_LAT-th enable cycle.
   initial begin : memory
      int mcnt;
      mcnt = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_en) begin
            mcnt++;
            if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
            if (mcnt == LAT)
               mem_rd = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : init_val(bus.mem_addr);
            else
               mem_rd = 32'hBAD0_0000 ^ 32'(mcnt);
         end else begin
            mcnt   = 0;
            mem_rd = 32'hBAD0_BAD0;
         end
      end
   end

   // Monitor / reference model
   initial begin : monitor
      logic cd_x, dd_x, en_x, g, hv;
      txn_t h;
      forever begin
         @(negedge clk);
         if (mon_on) begin
            en_x = (ph >= 1) && (ph <= LAT);
            cd_x = (ph == LAT + 1) && !own;
            dd_x = (ph == LAT + 1) &&  own;
            chk("busy",      32'(bus.busy),      32'(ph != 0));
            chk("mem_en",    32'(bus.mem_en),    32'(en_x));
            chk("cpu_done",  32'(bus.cpu_done),  32'(cd_x));
            chk("dma_done",  32'(bus.dma_done),  32'(dd_x));
            chk("cpu_rdata", bus.cpu_rdata, mrd0);
            chk("dma_rdata", bus.dma_rdata, mrd1);
            chk("cpu_stall", 32'(bus.cpu_stall), 32'(bus.cpu_req && !cd_x));
            hv = 1'b0;
            h  = '0;
            if (ph != 0) begin
               if (own ? (dq.size() > 0) : (cq.size() > 0)) begin
                  h  = own ? dq[0] : cq[0];
                  hv = 1'b1;
               end else begin
                  errors++;
                  $display("FAIL sb_empty port=%0d act=0 exp=1", own);
               end
            end
            if (en_x && hv) begin
               chk("mem_we",    32'(bus.mem_we), 32'(h.we));
               chk("mem_addr",  bus.mem_addr,    h.addr);
               chk("mem_wdata", bus.mem_wdata,   h.wdata);
            end else begin
               chk("mem_we_off", 32'(bus.mem_we), 32'd0);
            end
            if (ph == 1 && bus.mem_en) glog.push_back(int'(bus.mem_addr[5]));
            // advance model to next cycle
            if (rst) begin
               ph = 0; stv = 0; own = 1'b0; mrd0 = '0; mrd1 = '0;
            end else if (ph == 0) begin
               if (bus.cpu_req || bus.dma_req) begin
                  g   = bus.dma_req && (!bus.cpu_req || stv == LIM);
                  own = g;
                  ph  = 1;
                  if (g) stv = 0;
                  else if (bus.dma_req && stv < LIM) stv++;
                  else if (!bus.dma_req) stv = 0;
               end else begin
                  stv = 0;
               end
            end else if (ph < LAT) begin
               ph++;
            end else if (ph == LAT) begin
               ph++;
               if (hv && !h.we) begin
                  if (own) mrd1 = h.rd;
                  else     mrd0 = h.rd;
               end
            end else begin
               if (own && dq.size() > 0) void'(dq.pop_front());
               if (!own && cq.size() > 0) void'(cq.pop_front());
               ph = 0;
            end
         end
      end
   end

   // One transaction on port p; caller is at posedge+#1. Optionally drops req
   // and scrambles the request fields on the first BUSY cycle.
   task automatic one_txn(input int p, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input bit drop);
      txn_t t;
      bit   got, dropped;
      got = 0; dropped = 0;
      t.we = we; t.addr = a; t.wdata = d; t.rd = shadow_rd(p, a);
      if (we) begin
         if (p == 0) shadow0[a] = d;
         else        shadow1[a] = d;
      end
      if (p == 0) cq.push_back(t);
      else        dq.push_back(t);
      we_v[p] = we; addr_v[p] = a; wd_v[p] = d; req_v[p] = 1'b1;
      for (int i = 0; i < 150; i++) begin
         @(posedge clk); #1;
         if (drop && !dropped && bus.mem_en && bus.mem_addr == a) begin
            req_v[p] = 1'b0; addr_v[p] = a ^ 32'h4; we_v[p] = ~we; wd_v[p] = ~d;
            dropped = 1;
         end
         if (p == 0 ? bus.cpu_done : bus.dma_done) begin
            got = 1;
            break;
         end
      end
      if (!got) begin
         errors++;
         $display("FAIL done_timeout port=%0d act=0 exp=1", p);
      end
      req_v[p] = 1'b0;
   endtask

   task automatic run_port(input int p, input int n, input int maxgap, input int drop_pct);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
         a = (p == 0 ? 32'h00 : 32'h20) | (32'($urandom_range(7, 0)) << 2);
         one_txn(p, 1'($urandom_range(1, 0)), a, $urandom, ($urandom_range(99, 0) < drop_pct));
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (ph == 0 && cq.size() == 0 && dq.size() == 0) begin ok = 1; break; end
      end
      if (!ok) begin
         errors++;
         $display("FAIL idle_timeout act=busy exp=idle");
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   initial begin : main
      int c0;
      int exp3 [6];
      int exp4 [2];
      bit seen;
      exp3 = '{0, 0, 1, 0, 0, 1};
      exp4 = '{0, 1};
      addr_v[0] = '0; addr_v[1] = '0; wd_v[0] = '0; wd_v[1] = '0;
      rst = 1'b1;
      @(posedge clk); #1;
      mon_on = 1;
      repeat (2) begin @(posedge clk); #1; end
      chk("rst_busy",   32'(bus.busy),   32'd0);
      chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      chk("rst_maddr",  bus.mem_addr,    32'd0);
      chk("rst_crd",    bus.cpu_rdata,   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // CPU read of 0x10
      c0 = cyc;
      one_txn(0, 1'b0, 32'h10, 32'h0, 1'b0);
      chk("t1_latency", 32'(cyc - c0), 32'(LAT + 1));
      chk("t1_rdata",   bus.cpu_rdata, 32'hDEADBEEF);

      // DMA write
      one_txn(1, 1'b1, 32'h20, 32'h1234, 1'b0);
      chk("t2_dma_rdata", bus.dma_rdata, 32'h0);
      wait_idle();
      chk("t2_mem", mem_arr.exists(32'h20) ? mem_arr[32'h20] : 32'hX, 32'h1234);

      // starvation: both requesting continuously
      glog.delete();
      fork
         run_port(0, 4, 0, 0);
         run_port(1, 2, 0, 0);
      join
      wait_idle();
      chk("t3_ngrants", 32'(glog.size()), 32'd6);
      for (int i = 0; i < 6; i++)
         if (i < glog.size()) chk($sformatf("t3_grant%0d", i), 32'(glog[i]), 32'(exp3[i]));

      // CPU drops req / changes addr mid-BUSY, DMA queued behind it
      glog.delete();
      fork
         one_txn(0, 1'b0, 32'h08, 32'h0, 1'b1);
         begin @(posedge clk); #1; one_txn(1, 1'b0, 32'h28, 32'h0, 1'b0); end
      join
      wait_idle();
      chk("t4_ngrants", 32'(glog.size()), 32'd2);
      for (int i = 0; i < 2; i++)
         if (i < glog.size()) chk($sformatf("t4_grant%0d", i), 32'(glog[i]), 32'(exp4[i]));

      // reset on first BUSY cycle of a DMA write
      fork
         one_txn(1, 1'b1, 32'h2C, 32'hCAFE, 1'b0);
         begin
            seen = 0;
            for (int i = 0; i < 20; i++) begin
               @(posedge clk); #1;
               if (bus.mem_en) begin seen = 1; break; end
            end
            chk("t5_saw_busy", 32'(seen), 32'd1);
            rst = 1'b1;
            @(posedge clk); #1;
            chk("t5_busy",   32'(bus.busy),     32'd0);
            chk("t5_mem_en", 32'(bus.mem_en),   32'd0);
            chk("t5_done",   32'(bus.dma_done), 32'd0);
            rst = 1'b0;
         end
      join
      wait_idle();

      // randomized mix
      fork
         run_port(0, 40, 4, 20);
         run_port(1, 40, 4, 20);
      join
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
